// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding and parameter helpers for the sequential divisibility checker
package seq_div_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   function automatic int rem_width(input int divisor);
      return divisor <= 2 ? 1 : $clog2(divisor);
   endfunction
   function automatic int steps(input int width, input int bpc);
      return width / bpc;
   endfunction
endpackage

// File: rtl/seq_div_check_if.sv
// seq_div_check_if: word-in / remainder-out valid-ready bundle
//   in_data/in_valid/in_ready        : request channel (master drives data/valid)
//   out_rem/out_divisible/out_valid  : result channel (slave drives)
//   out_ready                        : result consumer ready (master drives)
interface seq_div_check_if #(parameter int WIDTH = 32, parameter int REM_W = 2);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [REM_W-1:0] out_rem;
   logic             out_divisible;
   logic             out_valid;
   logic             out_ready;
   modport master(output in_data, in_valid, out_ready, input in_ready, out_rem, out_divisible, out_valid);
   modport slave(input in_data, in_valid, out_ready, output in_ready, out_rem, out_divisible, out_valid);
endinterface

// File: rtl/seq_mod_step.sv
// seq_mod_step: one combinational Horner step, r_next = (r * 2^BITS_PER_CYCLE + chunk) mod DIVISOR
//   r      : running remainder
//   chunk  : next BITS_PER_CYCLE bits of the word, MSB-first
//   r_next : updated remainder
module seq_mod_step import seq_div_pkg::*; #(
   parameter int DIVISOR = 3,
   parameter int BITS_PER_CYCLE = 1,
   localparam int REM_W = rem_width(DIVISOR)
) (
   input  logic [REM_W-1:0]          r,
   input  logic [BITS_PER_CYCLE-1:0] chunk,
   output logic [REM_W-1:0]          r_next
);
   localparam int EW = REM_W + BITS_PER_CYCLE;
   logic [EW-1:0] acc;
   // concatenation is exactly r*2^BITS_PER_CYCLE + chunk at full width
   assign acc = {r, chunk};
   assign r_next = REM_W'(acc % EW'(DIVISOR));
endmodule

// File: rtl/seq_div_check.sv
// seq_div_check: sequential WIDTH-bit mod-DIVISOR checker, BITS_PER_CYCLE bits per clock
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seq_div_check_if (word in, remainder/divisible out)
module seq_div_check import seq_div_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int DIVISOR = 3,
   parameter int BITS_PER_CYCLE = 1,
   localparam int REM_W = rem_width(DIVISOR),
   localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE)
) (
   input logic           clk,
   input logic           rst,
   seq_div_check_if.slave bus
);
   localparam int CW = $clog2(STEPS + 1);
   if (DIVISOR < 2 || BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > WIDTH || WIDTH % BITS_PER_CYCLE != 0) begin : g_bad
      $error("seq_div_check: illegal DIVISOR/WIDTH/BITS_PER_CYCLE combination");
   end
   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [REM_W-1:0] r, r_next;
   logic [CW-1:0]    cnt;
   logic             accept;
   // accepting from DONE consumes the old result on the same edge
   assign bus.in_ready = !rst && (state == IDLE || (state == DONE && bus.out_ready));
   assign accept = bus.in_valid && bus.in_ready;
   seq_mod_step #(.DIVISOR(DIVISOR), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
      .r(r),
      .chunk(sh[WIDTH-1 -: BITS_PER_CYCLE]),
      .r_next(r_next)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r <= '0;
         cnt <= '0;
         bus.out_valid <= 1'b0;
         bus.out_rem <= '0;
         bus.out_divisible <= 1'b0;
      end else if (accept) begin
         sh <= bus.in_data;
         r <= '0;
         cnt <= CW'(STEPS);
         state <= BUSY;
         bus.out_valid <= 1'b0;
      end else if (state == BUSY) begin
         sh <= sh << BITS_PER_CYCLE;
         r <= r_next;
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            bus.out_rem <= r_next;
            bus.out_divisible <= r_next == '0;
            bus.out_valid <= 1'b1;
            state <= DONE;
         end
      end else if (state == DONE && bus.out_ready) begin
         state <= IDLE;
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seq_div_check.sv
// tb_seq_div_check: scoreboard bench for three seq_div_check configurations
module tb_seq_div_check;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   seq_div_check_if #(.WIDTH(32), .REM_W(2)) i0();
   seq_div_check_if #(.WIDTH(32), .REM_W(3)) i7();
   seq_div_check_if #(.WIDTH(16), .REM_W(4)) i10();
   seq_div_check u0 (.clk(clk), .rst(rst), .bus(i0));
   seq_div_check #(.WIDTH(32), .DIVISOR(7), .BITS_PER_CYCLE(4)) u7 (.clk(clk), .rst(rst), .bus(i7));
   seq_div_check #(.WIDTH(16), .DIVISOR(10), .BITS_PER_CYCLE(8)) u10 (.clk(clk), .rst(rst), .bus(i10));
   int q0[$], q7[$], q10[$];
   int n_checks = 0, n_pass = 0;
   int e0, e7, e10, n, v;
   logic [31:0] w;
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask
   always @(negedge clk) if (!rst && i0.out_valid && i0.out_ready) begin
      if (q0.size() == 0) chk("d3 unexpected result", 1, 0);
      else begin
         e0 = q0.pop_front();
         chk("d3 out_rem", int'(i0.out_rem), e0);
         chk("d3 out_divisible", int'(i0.out_divisible), int'(e0 == 0));
      end
   end
   always @(negedge clk) if (!rst && i7.out_valid && i7.out_ready) begin
      if (q7.size() == 0) chk("d7 unexpected result", 1, 0);
      else begin
         e7 = q7.pop_front();
         chk("d7 out_rem", int'(i7.out_rem), e7);
         chk("d7 out_divisible", int'(i7.out_divisible), int'(e7 == 0));
      end
   end
   always @(negedge clk) if (!rst && i10.out_valid && i10.out_ready) begin
      if (q10.size() == 0) chk("d10 unexpected result", 1, 0);
      else begin
         e10 = q10.pop_front();
         chk("d10 out_rem", int'(i10.out_rem), e10);
         chk("d10 out_divisible", int'(i10.out_divisible), int'(e10 == 0));
      end
   end
   task automatic send0(input logic [31:0] d, input int exp, input bit push);
      int t = 0;
      i0.in_data = d;
      i0.in_valid = 1'b1;
      while (!i0.in_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!i0.in_ready) chk("d3 accept timeout", 0, 1);
      else if (push) q0.push_back(exp);
      @(posedge clk); #1;
      i0.in_valid = 1'b0;
   endtask
   task automatic send7(input logic [31:0] d, input int exp);
      int t = 0;
      i7.in_data = d;
      i7.in_valid = 1'b1;
      while (!i7.in_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!i7.in_ready) chk("d7 accept timeout", 0, 1);
      else q7.push_back(exp);
      @(posedge clk); #1;
      i7.in_valid = 1'b0;
   endtask
   task automatic send10(input logic [15:0] d, input int exp);
      int t = 0;
      i10.in_data = d;
      i10.in_valid = 1'b1;
      while (!i10.in_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!i10.in_ready) chk("d10 accept timeout", 0, 1);
      else q10.push_back(exp);
      @(posedge clk); #1;
      i10.in_valid = 1'b0;
   endtask
   task automatic drain();
      int t = 0;
      while ((q0.size() + q7.size() + q10.size()) != 0 && t < 200) begin @(posedge clk); #1; t++; end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      i0.in_valid = 1'b0; i7.in_valid = 1'b0; i10.in_valid = 1'b0;
      i0.in_data = '0; i7.in_data = '0; i10.in_data = '0;
      i0.out_ready = 1'b1; i7.out_ready = 1'b1; i10.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", int'(i0.out_valid), 0);
      chk("reset out_rem", int'(i0.out_rem), 0);
      chk("reset out_divisible", int'(i0.out_divisible), 0);
      chk("reset in_ready", int'(i0.in_ready), 0);
      rst = 1'b0;
      #1;
      chk("idle in_ready", int'(i0.in_ready), 1);
      send0(32'hFFFFFFFF, 0, 1);
      n = 0;
      while (!i0.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("d3 latency", n, 32);
      send0(32'hFFFFFFFE, 2, 1);
      drain();
      i0.out_ready = 1'b0;
      send0(32'd10, 1, 1);
      i0.in_data = 32'd12;
      i0.in_valid = 1'b1;
      n = 0;
      while (!i0.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("hold out_valid rises", int'(i0.out_valid), 1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold out_valid", int'(i0.out_valid), 1);
         chk("hold out_rem", int'(i0.out_rem), 1);
         chk("hold out_divisible", int'(i0.out_divisible), 0);
         chk("hold in_ready", int'(i0.in_ready), 0);
      end
      i0.out_ready = 1'b1;
      q0.push_back(0);
      #1;
      chk("release in_ready", int'(i0.in_ready), 1);
      @(posedge clk); #1;
      i0.in_valid = 1'b0;
      chk("b2b out_valid drops", int'(i0.out_valid), 0);
      chk("b2b busy in_ready", int'(i0.in_ready), 0);
      drain();
      send0(32'd7, 1, 0);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid rst out_valid", int'(i0.out_valid), 0);
      chk("mid rst in_ready", int'(i0.in_ready), 0);
      rst = 1'b0;
      #1;
      chk("post rst in_ready", int'(i0.in_ready), 1);
      v = 0;
      repeat (40) begin @(posedge clk); #1; v += int'(i0.out_valid); end
      chk("post rst no output", v, 0);
      send0(32'd9, 0, 1);
      for (int k = 0; k < 200; k++) begin
         w = 32'hFFFFFFFF - 32'd100 + 32'(k);
         send0(w, int'(w % 32'd3), 1);
      end
      send7(32'd100, 2);
      n = 0;
      while (!i7.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("d7 latency", n, 8);
      send7(32'd0, 0);
      send7(32'hFFFFFFFF, 3);
      send10(16'hFFFF, 5);
      n = 0;
      while (!i10.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("d10 latency", n, 2);
      send10(16'd1230, 0);
      drain();
      chk("scoreboard drained", q0.size() + q7.size() + q10.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
